// File: rtl/match_controller.sv
// match_controller
//   Sequences a Pong match around the game-logic datapath: match FSM, scores,
//   serve timing and the slowed game tick.
// Ports
//   clk          system clock
//   rst          asynchronous, active-high reset
//   start        start/pause button (level, rising edge detected here)
//   miss_left    1-clk pulse, ball passed the left pad (point to right player)
//   miss_right   1-clk pulse, ball passed the right pad (point to left player)
//   tick         1-clk game-step enable, only while in PLAY
//   serve        1-clk pulse on the first PLAY clk after SERVE
//   serve_dir    launch direction: 0 toward left, 1 toward right
//   score_left   left player score
//   score_right  right player score
//   state        IDLE=0 SERVE=1 PLAY=2 PAUSE=3 OVER=4
//   winner       0 none, 1 left, 2 right
module match_controller #(
  parameter int TICK_DIV    = 18,
  parameter int SERVE_DELAY = 120,
  parameter int WIN_SCORE   = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       miss_left,
  input  logic       miss_right,
  output logic       tick,
  output logic       serve,
  output logic       serve_dir,
  output logic [3:0] score_left,
  output logic [3:0] score_right,
  output logic [2:0] state,
  output logic [1:0] winner
);

  // The delay counter only ever reaches SERVE_DELAY-1.
  localparam int            DW         = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
  localparam logic [DW-1:0] DELAY_LAST = DW'(SERVE_DELAY - 1);
  localparam logic [3:0]    WIN        = 4'(WIN_SCORE);
  localparam logic [3:0]    WIN_M1     = 4'(WIN_SCORE - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    PAUSE = 3'd3,
    OVER  = 3'd4
  } state_t;

  state_t              state_reg, state_next;
  logic [TICK_DIV-1:0] presc_reg;
  logic [DW-1:0]       delay_reg, delay_next;
  logic [3:0]          score_left_reg, score_left_next;
  logic [3:0]          score_right_reg, score_right_next;
  logic [1:0]          winner_reg, winner_next;
  logic                serve_dir_reg, serve_dir_next;
  logic                serve_reg, serve_next;
  logic                tick_reg;
  logic                start_q;
  logic                start_edge;
  logic                tick_raw;

  assign start_edge = start & ~start_q;
  assign tick_raw   = &presc_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      presc_reg       <= '0;
      delay_reg       <= '0;
      score_left_reg  <= 4'd0;
      score_right_reg <= 4'd0;
      winner_reg      <= 2'd0;
      serve_dir_reg   <= 1'b1;
      serve_reg       <= 1'b0;
      tick_reg        <= 1'b0;
      // A button held through reset must not count as a press.
      start_q         <= 1'b1;
    end else begin
      state_reg       <= state_next;
      presc_reg       <= presc_reg + 1'b1;
      delay_reg       <= delay_next;
      score_left_reg  <= score_left_next;
      score_right_reg <= score_right_next;
      winner_reg      <= winner_next;
      serve_dir_reg   <= serve_dir_next;
      serve_reg       <= serve_next;
      // Gated by the current (registered) state, so tick lags tick_raw by 1 clk.
      tick_reg        <= tick_raw && (state_reg == PLAY);
      start_q         <= start;
    end
  end

  always_comb begin
    state_next       = state_reg;
    delay_next       = delay_reg;
    score_left_next  = score_left_reg;
    score_right_next = score_right_reg;
    winner_next      = winner_reg;
    serve_dir_next   = serve_dir_reg;
    serve_next       = 1'b0;

    case (state_reg)
      IDLE: begin
        score_left_next  = 4'd0;
        score_right_next = 4'd0;
        winner_next      = 2'd0;
        if (start_edge) begin
          state_next     = SERVE;
          serve_dir_next = 1'b1;
          delay_next     = '0;
        end
      end

      SERVE: begin
        if (tick_raw) begin
          if (delay_reg == DELAY_LAST) begin
            state_next = PLAY;
            serve_next = 1'b1;
          end else begin
            delay_next = delay_reg + 1'b1;
          end
        end
      end

      PLAY: begin
        // miss_left outranks miss_right, and any miss outranks start.
        if (miss_left) begin
          serve_dir_next = 1'b0;
          if (score_right_reg >= WIN_M1) begin
            score_right_next = WIN;
            winner_next      = 2'd2;
            state_next       = OVER;
          end else begin
            score_right_next = score_right_reg + 4'd1;
            state_next       = SERVE;
            delay_next       = '0;
          end
        end else if (miss_right) begin
          serve_dir_next = 1'b1;
          if (score_left_reg >= WIN_M1) begin
            score_left_next = WIN;
            winner_next     = 2'd1;
            state_next      = OVER;
          end else begin
            score_left_next = score_left_reg + 4'd1;
            state_next      = SERVE;
            delay_next      = '0;
          end
        end else if (start_edge) begin
          state_next = PAUSE;
        end
      end

      PAUSE: begin
        if (start_edge) begin
          state_next = PLAY;
        end
      end

      OVER: begin
        if (start_edge) begin
          state_next       = IDLE;
          score_left_next  = 4'd0;
          score_right_next = 4'd0;
          winner_next      = 2'd0;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign tick        = tick_reg;
  assign serve       = serve_reg;
  assign serve_dir   = serve_dir_reg;
  assign score_left  = score_left_reg;
  assign score_right = score_right_reg;
  assign state       = state_reg;
  assign winner      = winner_reg;

endmodule
